// File: rtl/div_subshift_sr.sv
// div_subshift_sr: multi-cycle shift-subtract integer divider.
// Supports a per-operation signed/unsigned mode and optional round-half-away
// quotient rounding. Divide-by-zero and signed overflow are flagged.
// Every operation has the same latency: the result appears DATA_W+2 edges
// after start is accepted.
module div_subshift_sr #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_en,
    input  logic              round_en,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero,
    output logic              overflow
);

    localparam logic [DATA_W-1:0] LP_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] LP_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] LP_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] LP_MSB  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  LP_CNT1 = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negation.
    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] a);
        return (~a) + LP_ONE;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    // Latched operation context
    logic              r_round;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_dbz;
    logic              r_ovf;
    logic [DATA_W-1:0] r_dsr;       // |divisor|
    logic [DATA_W-1:0] r_dvd_mag;   // |dividend|, kept for the divide-by-zero remainder
    logic [CNT_W-1:0]  r_cnt;

    // Working registers: r_acc shifts dividend bits out and quotient bits in.
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_rem;

    logic              w_accept;
    logic              w_dvd_neg;
    logic              w_dsr_neg;
    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dsr_mag;
    logic [DATA_W:0]   w_trial;
    logic              w_borrow;
    logic              w_round_up;
    logic [DATA_W-1:0] w_qmag;
    logic [DATA_W-1:0] w_q_fix;
    logic [DATA_W-1:0] w_r_fix;

    // start is honoured only in IDLE or DONE, and only once busy has dropped.
    assign w_accept  = start && !busy && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_dvd_neg = signed_en && dividend[DATA_W-1];
    assign w_dsr_neg = signed_en && divisor[DATA_W-1];
    assign w_dvd_mag = w_dvd_neg ? f_neg(dividend) : dividend;
    assign w_dsr_mag = w_dsr_neg ? f_neg(divisor) : divisor;

    // One restoring step; bit DATA_W of the trial difference is the borrow.
    assign w_trial  = {r_rem, r_acc[DATA_W-1]} - {1'b0, r_dsr};
    assign w_borrow = w_trial[DATA_W];

    // FIX-stage result: rounding, sign restoration and special cases.
    always_comb begin
        w_round_up = 1'b0;
        w_qmag     = r_acc;
        w_q_fix    = r_acc;
        w_r_fix    = r_rem;
        if (r_round && ({r_rem, 1'b0} >= {1'b0, r_dsr})) begin
            w_round_up = 1'b1;
        end else begin
            w_round_up = 1'b0;
        end
        w_qmag = r_acc + (w_round_up ? LP_ONE : LP_ZERO);
        if (r_dbz) begin
            // Re-signing |dividend| restores the original dividend bit pattern.
            w_q_fix = LP_ONES;
            w_r_fix = r_sign_r ? f_neg(r_dvd_mag) : r_dvd_mag;
        end else if (r_ovf) begin
            w_q_fix = LP_MSB;
            w_r_fix = LP_ZERO;
        end else begin
            w_q_fix = r_sign_q ? f_neg(w_qmag) : w_qmag;
            w_r_fix = r_sign_r ? f_neg(r_rem) : r_rem;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ITER;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = ST_FIX;
                end else begin
                    w_state_nxt = ST_ITER;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ITER;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, fix-up and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round     <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_dsr       <= LP_ZERO;
            r_dvd_mag   <= LP_ZERO;
            r_cnt       <= {CNT_W{1'b0}};
            r_acc       <= LP_ZERO;
            r_rem       <= LP_ZERO;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= LP_ZERO;
            remainder   <= LP_ZERO;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (w_accept) begin
            r_round   <= round_en;
            r_sign_q  <= w_dvd_neg ^ w_dsr_neg;
            r_sign_r  <= w_dvd_neg;
            r_dbz     <= (divisor == LP_ZERO);
            r_ovf     <= signed_en && (dividend == LP_MSB) && (divisor == LP_ONES);
            r_dsr     <= w_dsr_mag;
            r_dvd_mag <= w_dvd_mag;
            r_cnt     <= {CNT_W{1'b0}};
            r_acc     <= w_dvd_mag;
            r_rem     <= LP_ZERO;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            case (r_state)
                ST_ITER: begin
                    if (w_borrow) begin
                        r_rem <= {r_rem[DATA_W-2:0], r_acc[DATA_W-1]};
                    end else begin
                        r_rem <= w_trial[DATA_W-1:0];
                    end
                    r_acc <= {r_acc[DATA_W-2:0], ~w_borrow};
                    r_cnt <= r_cnt + LP_CNT1;
                end
                ST_FIX: begin
                    r_acc <= w_q_fix;
                    r_rem <= w_r_fix;
                end
                ST_DONE: begin
                    // The first DONE cycle publishes; afterwards the outputs hold.
                    if (busy) begin
                        quotient    <= r_acc;
                        remainder   <= r_rem;
                        div_by_zero <= r_dbz;
                        overflow    <= r_ovf;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        done <= done;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_subshift_sr.sv
// Directed testbench for div_subshift_sr with DATA_W = 8.
module tb_div_subshift_sr;

    logic       clk;
    logic       rst;
    logic       start;
    logic       signed_en;
    logic       round_en;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    div_subshift_sr #(.DATA_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_en   (signed_en),
        .round_en    (round_en),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation from a negedge and check latency, handshake and result.
    // rep re-pulses start (with other operands) so edges 3 and 5 see it.
    task automatic op(input logic sg, input logic rd, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eov, input logic rep);
        int bad;
        signed_en = sg;
        round_en  = rd;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividend  = 8'hA5;
        divisor   = 8'h3C;
        signed_en = ~sg;
        round_en  = ~rd;
        chk("accept", {14'd0, busy, done}, 16'h0002);
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && done === 1'b0)) bad++;
            if (rep && (k == 2 || k == 4)) begin
                start    = 1'b1;
                dividend = 8'h11;
                divisor  = 8'h01;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("busy_window", 16'(bad), 16'd0);
        chk("done",        16'(done), 16'd1);
        chk("busy_end",    16'(busy), 16'd0);
        chk("quotient",    16'(quotient), 16'(eq));
        chk("remainder",   16'(remainder), 16'(er));
        chk("div_by_zero", 16'(div_by_zero), 16'(edz));
        chk("overflow",    16'(overflow), 16'(eov));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        signed_en = 1'b0;
        round_en  = 1'b0;
        dividend  = 8'h00;
        divisor   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_flags", {12'd0, busy, done, div_by_zero, overflow}, 16'h0000);
        chk("rst_data",  {quotient, remainder}, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned truncate / round
        op(1'b0, 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b1, 8'd200, 8'd7, 8'd29, 8'd4, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b1, 8'd100, 8'd8, 8'd13, 8'd4, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b1, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
        // Signed
        op(1'b1, 1'b0, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b1, 8'hF9, 8'h02, 8'hFC, 8'hFF, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b1, 8'h80, 8'h03, 8'hD5, 8'hFE, 1'b0, 1'b0, 1'b0);
        // Special cases
        op(1'b0, 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b0, 8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b0, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
        // start re-pulsed mid-operation is ignored
        op(1'b0, 1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 1'b1);
        // Back-to-back: the second op starts on the done cycle of the first
        op(1'b0, 1'b1, 8'd100, 8'd8, 8'd13, 8'd4, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an operation
        signed_en = 1'b0;
        round_en  = 1'b0;
        dividend  = 8'd200;
        divisor   = 8'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {12'd0, busy, done, div_by_zero, overflow}, 16'h0000);
        chk("midrst_data",  {quotient, remainder}, 16'h0000);
        op(1'b1, 1'b0, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_subshift_sr.md
Name: div_subshift_sr

Overview:
- Parametrised, multi-cycle shift-subtract integer divider; successor to the fixed unsigned subtract-shift divider.
- Adds a per-operation signed/unsigned mode and optional round-to-nearest of the quotient.
- Adds divide-by-zero and signed-overflow detection, and a start/busy/done handshake with constant latency.
- Used by datapath blocks needing integer or scaled division without a combinational divider.

Parameters:
- DATA_W, 32: operand and result width in bits (>= 4).
- CNT_W, $clog2(DATA_W+1): iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; accepted only when busy=0.
- signed_en  input  1  1 = two's-complement operands and results; 0 = unsigned. Sampled with start.
- round_en  input  1  1 = quotient rounded to nearest, half away from zero; 0 = truncate toward zero. Sampled with start.
- dividend  input  DATA_W  numerator, sampled with start.
- divisor  input  DATA_W  denominator, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  result valid; held until next accepted start or rst.
- quotient  output  DATA_W  result quotient.
- remainder  output  DATA_W  truncated remainder.
- div_by_zero  output  1  last operation had divisor = 0; valid with done.
- overflow  output  1  last operation was signed most-negative / -1; valid with done.

Behaviour:
- Reset: when rst=1 at a clock edge, the block goes to IDLE and busy, done, quotient, remainder, div_by_zero and overflow all become 0. This applies at any point, including mid-operation; the operation in progress is discarded.
- FSM states and transitions:
  - IDLE: on start, go to ITER.
  - ITER: go to FIX after exactly DATA_W cycles.
  - FIX: go to DONE.
  - DONE: on start, go to ITER; otherwise stay.
- Accepting start (in IDLE or DONE, at edge T):
  - Latch signed_en and round_en.
  - Latch |dividend| and |divisor|; the abs() is taken only when signed_en=1.
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); both are 0 when unsigned.
  - Clear done, set busy, clear the counter.
- start while busy=1 is ignored. Inputs may change freely after acceptance.
- ITER, one cycle per quotient bit, MSB first:
  - Form trial = {rem, next dividend bit} - |divisor|, computed at DATA_W+1 bits so the borrow is visible.
  - No borrow: rem <= trial and the quotient bit is 1.
  - Borrow: rem <= {rem, bit} and the quotient bit is 0.
  - The counter increments each cycle; the FSM leaves ITER when the counter reaches DATA_W-1.
- FIX:
  - When round_en=1 and 2*rem >= |divisor|, the magnitude of q increments. The comparison is done at DATA_W+1 bits and cannot overflow for divisor != 0.
  - Negate q when sign_q=1; negate rem when sign_r=1.
  - The remainder output always reports the truncated remainder, even when the quotient was rounded.
- Special cases, resolved in FIX at the same latency:
  - divisor = 0: quotient = all ones, remainder = original dividend, div_by_zero=1. This holds for either mode.
  - signed_en=1, dividend = 100...0, divisor = all ones: quotient = 100...0, remainder = 0, overflow=1.
- Latency: start accepted at edge T gives done=1 and busy=0 from edge T+DATA_W+2.
  - Results and flags update on that same edge and remain stable while in DONE.
- Back-to-back: start asserted while done=1 is accepted on that edge and done drops the next cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- DATA_W=8, unsigned, 200/7, round_en=0 -> after 10 cycles: quotient=28, remainder=4, busy 1 for cycles 1..9, done=1 at cycle 10.
- Same operands with round_en=1 -> quotient=29, remainder=4; 100/8 rounded (12.5) -> 13.
- Signed, -7/2: truncate -> quotient=0xFD (-3), remainder=0xFF (-1). round_en=1 -> quotient=0xFC (-4).
- Signed, 7/-2 -> quotient=0xFD, remainder=0x01.
- 0x55/0 (either mode) -> quotient=0xFF, remainder=0x55, div_by_zero=1, overflow=0. Signed 0x80/0xFF -> quotient=0x80, remainder=0, overflow=1. Both arrive at the normal latency.
- Back-to-back and interference checks:
  - start re-pulsed at cycles 3 and 5 of an operation -> ignored, result unchanged.
  - start asserted on the done cycle -> second result after a further 10 cycles.
  - rst at cycle 4 -> next edge: busy=0, done=0, all outputs 0; a following start computes correctly.
